sdrd_mb: RTL and testbench
==========================

Name: sdrd_mb

Overview:
- Multi-sector successor to the single-sector SD/TF reader peripheral.
- Attaches to the SoC as an ICB slave and drives an external 1-bit SD sector-read engine (the existing sd_reader interface).
- Streams COUNT consecutive 512-byte sectors into NUM_BUF ping-pong sector buffers, with per-buffer release handshake, 32-bit packed buffer reads, abort, and a completion interrupt.

Parameters:
- NUM_BUF, 2: number of 512-byte sector buffers; power of two, 2..8.
- BUF_BITS, 1: log2(NUM_BUF).
- CNT_W, 16: width of the sector-count register.
- CARD_READY, 4'hA: card_stat value that qualifies rdone as a valid sector completion.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sdrd_icb_cmd_valid  in  1  ICB command valid
- sdrd_icb_cmd_ready  out  1  ICB command ready
- sdrd_icb_cmd_addr  in  32  byte address; bit13=1 selects the buffer window, bit13=0 selects registers
- sdrd_icb_cmd_read  in  1  1=read, 0=write
- sdrd_icb_cmd_wdata  in  32  write data
- sdrd_icb_cmd_wmask  in  4  byte strobes; ignored, all register writes are full-word
- sdrd_icb_rsp_valid  out  1  response valid
- sdrd_icb_rsp_ready  in  1  response ready
- sdrd_icb_rsp_err  out  1  response error
- sdrd_icb_rsp_rdata  out  32  read data
- rstart  out  1  engine start; held high until the qualified rdone
- rsector  out  32  sector number for the engine
- rbusy  in  1  engine busy; reported in STATUS only
- rdone  in  1  one-cycle pulse at sector end
- card_stat  in  4  engine card state
- card_type  in  2  card type
- outen  in  1  engine byte-write strobe
- outaddr  in  9  byte offset within the sector
- outbyte  in  8  byte data
- irq  out  1  level interrupt = done_flag & irq_en

Behaviour:
- Reset: rsp_valid=0, rstart=0, irq=0, SECTOR=0, COUNT=0, irq_en=0, full[]=0, fill_bank=0, state=IDLE. Buffer contents are not reset.
- ICB handshake:
  - cmd_ready = ~rsp_valid | rsp_ready.
  - Every accepted cmd, read or write, produces exactly one response; rsp_valid rises the cycle after acceptance.
  - rsp_valid holds until rsp_ready is sampled high.
  - rdata and err are registered and stable while rsp_valid=1.
- Register map, bit13=0, word-addressed by addr[4:2]:
  - 0x00 SECTOR (RW): start sector.
  - 0x04 COUNT (RW): bits [CNT_W-1:0]; reads return the sectors remaining.
  - 0x08 CTRL (W):
    - bit0 START: accepted only in IDLE with COUNT!=0.
    - bit1 ABORT.
    - bit2 irq_en, also readable at this address.
    - bits[8+NUM_BUF-1:8]: write 1 to release buffer k.
  - 0x0C STATUS (RO):
    - [31:24] rsvd 0
    - [23:22] state
    - [21:20] card_type
    - [19:16] card_stat
    - [15:8] full[]
    - [7:5] fill_bank
    - [4] rbusy
    - [1] err_flag
    - [0] done_flag
  - 0x10 IRQCLR (W): any write clears done_flag and err_flag.
- Buffer window, bit13=1:
  - Word index = addr[8+BUF_BITS:2]; bank = upper BUF_BITS bits of that index.
  - Reads return 4 little-endian bytes (byte n = offset 4*i+n).
  - Writes to the window are dropped with rsp_err=1.
  - A read of a bank that is not full returns the stale data with err=0.
- rsp_err=1 cases:
  - Unmapped register offset.
  - START when not IDLE or COUNT==0; err_flag is also set.
  - Write to SECTOR or COUNT while not IDLE; the write is ignored.
- Engine write path: on outen, byte written to bank fill_bank at offset outaddr. Write-port and ICB-read collisions to the same word return the old data.
- FSM:
  - IDLE: START -> WAIT_BUF. done_flag is cleared on START.
  - WAIT_BUF: if ~full[fill_bank] -> READ, rstart=1, rsector=SECTOR.
  - READ: on rdone & card_stat==CARD_READY:
    - rstart=0, full[fill_bank]=1, fill_bank+=1 (mod NUM_BUF), SECTOR+=1 (32-bit wrap), COUNT-=1.
    - If the new COUNT==0 -> IDLE and set done_flag; else -> WAIT_BUF.
  - rdone with card_stat!=CARD_READY is ignored.
  - ABORT (ABORT written in WAIT_BUF or READ):
    - From WAIT_BUF -> IDLE immediately.
    - From READ -> keep rstart until qualified rdone, discard that sector (no full set, COUNT unchanged), then IDLE.
    - Abort sets done_flag.
  - ABORT in IDLE is a no-op.
- Release and full[k] set in the same cycle for the same k: set wins.
- A START write with release bits in the same CTRL word: releases are applied first.
- state encoding: IDLE=0, WAIT_BUF=1, READ=2, ABORT=3.

Test Plan:
- Reset, then read STATUS -> rdata=0x0000_0000 apart from card_type/card_stat/rbusy fields; rsp_err=0; irq=0.
- SECTOR=0x100, COUNT=2, CTRL=0x5; engine model writes bytes (i&0xFF) ->
  - rsector=0x100 then 0x101; full=0b11; done_flag=1; irq=1.
  - Window word 0 reads 0x03020100; word 128 (bank1) reads 0x03020100.
- COUNT=3, no releases -> after two sectors, state stays WAIT_BUF with rstart=0; CTRL write 0x100 (release bank0) -> third sector starts at rsector=SECTOR+2 into bank0.
- ABORT mid-READ of sector 0x200 -> rstart stays high until rdone; then state=IDLE, full unchanged, COUNT unchanged, done_flag=1.
- Error responses, each -> rsp_err=1 and no state change:
  - START with COUNT=0.
  - Write to 0x2000.
  - Write to 0x14.
  - SECTOR write while busy.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read -> cmd_ready=0, rsp_valid and rdata stable; release -> next cmd accepted the same cycle.

Source files
------------

// File: rtl/sdrd_mb.sv
// sdrd_mb: multi-sector SD sector reader front end.
// Sits on the ICB bus as a slave and sequences an external 1-bit SD
// sector-read engine. COUNT consecutive sectors starting at SECTOR are
// streamed into NUM_BUF ping-pong 512-byte buffers. Software drains each
// buffer through a 32-bit read window and then releases it.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sdrd_icb_cmd_*      ICB command channel (addr bit13 selects the buffer window)
//   sdrd_icb_rsp_*      ICB response channel (registered, one response per command)
//   rstart, rsector     engine start request and sector number
//   rbusy, rdone        engine busy level and end-of-sector pulse
//   card_stat/card_type engine card state, reported in STATUS
//   outen/outaddr/outbyte engine byte-write port into the fill buffer
//   irq                 level interrupt, done_flag & irq_en
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no transfer in progress
// WAIT_BUF | next sector pending, waiting for buffer fill_bank to be free
// READ     | engine started (rstart high), waiting for a qualified rdone
// ABORT    | abort requested mid-sector; draining the current sector
module sdrd_mb #(
  parameter int          NUM_BUF    = 2,
  parameter int          BUF_BITS   = 1,
  parameter int          CNT_W      = 16,
  parameter logic [3:0]  CARD_READY = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdrd_icb_cmd_valid,
  output logic        sdrd_icb_cmd_ready,
  input  logic [31:0] sdrd_icb_cmd_addr,
  input  logic        sdrd_icb_cmd_read,
  input  logic [31:0] sdrd_icb_cmd_wdata,
  input  logic [3:0]  sdrd_icb_cmd_wmask,
  output logic        sdrd_icb_rsp_valid,
  input  logic        sdrd_icb_rsp_ready,
  output logic        sdrd_icb_rsp_err,
  output logic [31:0] sdrd_icb_rsp_rdata,
  output logic        rstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic [3:0]  card_stat,
  input  logic [1:0]  card_type,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUF = 2'd1,
    READ     = 2'd2,
    ABORT    = 2'd3
  } state_t;

  localparam int WORDS = NUM_BUF * 128;
  localparam int IDX_W = BUF_BITS + 7;

  logic [3:0][7:0]     buf_mem [WORDS];

  state_t              state;
  logic [31:0]         sector;
  logic [CNT_W-1:0]    count;
  logic                irq_en;
  logic                done_flag;
  logic                err_flag;
  logic [NUM_BUF-1:0]  full;
  logic [BUF_BITS-1:0] fill_bank;

  logic                cmd_acc;
  logic                sel_buf;
  logic [2:0]          reg_idx;
  logic                reg_wr;
  logic                wr_sector;
  logic                wr_count;
  logic                wr_ctrl;
  logic                wr_irqclr;
  logic                busy;
  logic                start_ok;
  logic                start_bad;
  logic                abort_req;
  logic                qual_done;
  logic [NUM_BUF-1:0]  release_mask;
  logic [NUM_BUF-1:0]  set_mask;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [31:0]         reg_rdata;
  logic                reg_err;
  logic [31:0]         status_word;
  logic [31:0]         count_word;
  logic                unused_ok;

  assign sdrd_icb_cmd_ready = ~sdrd_icb_rsp_valid | sdrd_icb_rsp_ready;
  assign cmd_acc   = sdrd_icb_cmd_valid & sdrd_icb_cmd_ready;
  assign sel_buf   = sdrd_icb_cmd_addr[13];
  assign reg_idx   = sdrd_icb_cmd_addr[4:2];
  assign reg_wr    = cmd_acc & ~sdrd_icb_cmd_read & ~sel_buf;
  assign wr_sector = reg_wr & (reg_idx == 3'd0);
  assign wr_count  = reg_wr & (reg_idx == 3'd1);
  assign wr_ctrl   = reg_wr & (reg_idx == 3'd2);
  assign wr_irqclr = reg_wr & (reg_idx == 3'd4);
  assign busy      = (state != IDLE);
  assign start_ok  = wr_ctrl & sdrd_icb_cmd_wdata[0] & ~busy & (count != '0);
  assign start_bad = wr_ctrl & sdrd_icb_cmd_wdata[0] & ~(~busy & (count != '0));
  assign abort_req = wr_ctrl & sdrd_icb_cmd_wdata[1];
  assign qual_done = rdone & (card_stat == CARD_READY);
  assign release_mask = wr_ctrl ? sdrd_icb_cmd_wdata[8 +: NUM_BUF] : '0;
  assign rd_idx    = sdrd_icb_cmd_addr[8+BUF_BITS:2];
  assign wr_idx    = {fill_bank, outaddr[8:2]};
  assign irq       = done_flag & irq_en;

  assign unused_ok = ^{sdrd_icb_cmd_wmask, sdrd_icb_cmd_addr[31:14],
                       sdrd_icb_cmd_addr[12:9], sdrd_icb_cmd_addr[1:0]};

  always_comb begin
    // A completing sector marks its bank full; applied after releases so set wins.
    set_mask = '0;
    if (state == READ && qual_done && !abort_req) begin
      set_mask[fill_bank] = 1'b1;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[23:22]            = state;
    status_word[21:20]            = card_type;
    status_word[19:16]            = card_stat;
    status_word[8 +: NUM_BUF]     = full;
    status_word[5 +: BUF_BITS]    = fill_bank;
    status_word[4]                = rbusy;
    status_word[1]                = err_flag;
    status_word[0]                = done_flag;
    count_word = '0;
    count_word[CNT_W-1:0]         = count;
  end

  always_comb begin
    reg_rdata = '0;
    reg_err   = 1'b0;
    if (sel_buf) begin
      reg_err = ~sdrd_icb_cmd_read;
    end else begin
      case (reg_idx)
        3'd0: begin
          reg_rdata = sector;
          reg_err   = ~sdrd_icb_cmd_read & busy;
        end
        3'd1: begin
          reg_rdata = count_word;
          reg_err   = ~sdrd_icb_cmd_read & busy;
        end
        3'd2: begin
          reg_rdata[2] = irq_en;
          reg_err      = start_bad;
        end
        3'd3: reg_rdata = status_word;
        3'd4: reg_rdata = '0;
        default: reg_err = 1'b1;
      endcase
    end
  end

  // Sector buffer: byte-lane writes from the engine, word reads from ICB.
  // A same-word collision returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (outen) begin
      buf_mem[wr_idx][outaddr[1:0]] <= outbyte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdrd_icb_rsp_valid <= 1'b0;
      sdrd_icb_rsp_err   <= 1'b0;
      sdrd_icb_rsp_rdata <= '0;
    end else if (cmd_acc) begin
      sdrd_icb_rsp_valid <= 1'b1;
      sdrd_icb_rsp_err   <= reg_err;
      sdrd_icb_rsp_rdata <= (sel_buf & sdrd_icb_cmd_read) ? buf_mem[rd_idx] : reg_rdata;
    end else if (sdrd_icb_rsp_ready) begin
      sdrd_icb_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sector    <= '0;
      count     <= '0;
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
      full      <= '0;
      fill_bank <= '0;
      rstart    <= 1'b0;
      rsector   <= '0;
    end else begin
      if (wr_sector && !busy) sector <= sdrd_icb_cmd_wdata;
      if (wr_count && !busy)  count  <= sdrd_icb_cmd_wdata[CNT_W-1:0];
      if (wr_ctrl)            irq_en <= sdrd_icb_cmd_wdata[2];
      if (wr_irqclr) begin
        done_flag <= 1'b0;
        err_flag  <= 1'b0;
      end
      if (start_bad) err_flag <= 1'b1;
      full <= (full & ~release_mask) | set_mask;

      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= WAIT_BUF;
            done_flag <= 1'b0;
          end
        end
        WAIT_BUF: begin
          if (abort_req) begin
            state     <= IDLE;
            done_flag <= 1'b1;
          end else if (!full[fill_bank]) begin
            state   <= READ;
            rstart  <= 1'b1;
            rsector <= sector;
          end
        end
        READ: begin
          if (qual_done) begin
            rstart <= 1'b0;
            if (abort_req) begin
              // Abort landing on the completing edge discards this sector.
              state     <= IDLE;
              done_flag <= 1'b1;
            end else begin
              fill_bank <= fill_bank + BUF_BITS'(1);
              sector    <= sector + 32'd1;
              count     <= count - CNT_W'(1);
              if (count == CNT_W'(1)) begin
                state     <= IDLE;
                done_flag <= 1'b1;
              end else begin
                state <= WAIT_BUF;
              end
            end
          end else if (abort_req) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          if (qual_done) begin
            rstart    <= 1'b0;
            state     <= IDLE;
            done_flag <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrd_mb.sv
// tb_sdrd_mb: scoreboard bench for sdrd_mb. Commands push their expected
// response into a queue; a monitor pops and compares on every response
// handshake. A sector-level reference model tracks registers, buffer
// occupancy and buffer bytes.
module tb_sdrd_mb;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        rstart;
  logic [31:0] rsector;
  logic        rbusy, rdone;
  logic [3:0]  card_stat;
  logic [1:0]  card_type;
  logic        outen;
  logic [8:0]  outaddr;
  logic [7:0]  outbyte;
  logic        irq;

  localparam logic [31:0] A_SECTOR = 32'h0, A_COUNT = 32'h4, A_CTRL = 32'h8,
                          A_STATUS = 32'hC, A_IRQCLR = 32'h10, A_BUF = 32'h2000;

  always #5 clk = ~clk;

  sdrd_mb dut (
    .clk(clk), .rst(rst),
    .sdrd_icb_cmd_valid(cmd_valid), .sdrd_icb_cmd_ready(cmd_ready),
    .sdrd_icb_cmd_addr(cmd_addr), .sdrd_icb_cmd_read(cmd_read),
    .sdrd_icb_cmd_wdata(cmd_wdata), .sdrd_icb_cmd_wmask(cmd_wmask),
    .sdrd_icb_rsp_valid(rsp_valid), .sdrd_icb_rsp_ready(rsp_ready),
    .sdrd_icb_rsp_err(rsp_err), .sdrd_icb_rsp_rdata(rsp_rdata),
    .rstart(rstart), .rsector(rsector), .rbusy(rbusy), .rdone(rdone),
    .card_stat(card_stat), .card_type(card_type),
    .outen(outen), .outaddr(outaddr), .outbyte(outbyte), .irq(irq)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // reference model
  logic [31:0] m_sector;
  int          m_count;
  bit          m_irq_en, m_done, m_err;
  bit [1:0]    m_full;
  int          m_fill;
  int          m_state;   // 0 idle, 1 waiting for buffer, 2 reading, 3 aborting
  logic [7:0]  m_mem [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %b with empty scoreboard", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        if (((rsp_rdata & e.mask) !== (e.data & e.mask)) || (rsp_err !== e.err)) begin
          errors++;
          $display("FAIL %s: got data %h err %b expected data %h err %b (mask %h)",
                   e.name, rsp_rdata, rsp_err, e.data, e.err, e.mask);
        end
      end
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[23:22] = 2'(m_state);
    s[21:20] = card_type;
    s[19:16] = card_stat;
    s[9:8]   = m_full;
    s[7:5]   = 3'(m_fill);
    s[4]     = rbusy;
    s[1]     = m_err;
    s[0]     = m_done;
    return s;
  endfunction

  function automatic logic [31:0] mem_word(input int w);
    return {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
  endfunction

  task automatic icb(input string nm, input logic [31:0] a, input bit rd,
                     input logic [31:0] wd, input logic [31:0] ed,
                     input logic [31:0] em, input bit ee, input bit sync);
    int   n;
    exp_t e;
    n = 0;
    if (sync) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd; cmd_wdata = wd;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL %s: cmd_ready timeout, got 0 expected 1", nm);
      cmd_valid = 1'b0;
      return;
    end
    e.name = nm; e.data = ed; e.mask = em; e.err = ee;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d, input bit ee);
    icb(nm, a, 1'b0, d, 32'h0, 32'h0, ee, 1'b1);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] ed);
    icb(nm, a, 1'b1, 32'h0, ed, 32'hFFFF_FFFF, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
    end
  endtask

  // Engine model: one sector, optional ignored rdone, optional abort mid-sector.
  task automatic engine(input bit pat, input bit do_abort);
    int         n;
    logic [7:0] b;
    n = 0;
    @(negedge clk);
    while (!rstart && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rstart) begin
      errors++;
      $display("FAIL rstart_timeout: got 0 expected 1");
      return;
    end
    check("rsector", rsector, m_sector);
    m_state = 2;
    @(posedge clk); #1;
    rbusy = 1'b1; rdone = 1'b1; card_stat = 4'h3;   // not ready: must be ignored
    @(posedge clk); #1;
    rdone = 1'b0; card_stat = 4'h5;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      b = pat ? 8'(i) : 8'($urandom);
      outen = 1'b1; outaddr = 9'(i); outbyte = b;
      m_mem[m_fill*512 + i] = b;
      if (do_abort && i == 255) begin
        @(posedge clk); #1;
        outen = 1'b0;
        wr("ctrl_abort_read", A_CTRL, 32'h6, 1'b0);
        m_state = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstart_held_abort", 32'(rstart), 32'h1);
        rd("status_aborting", A_STATUS, exp_status());
      end
    end
    @(posedge clk); #1;
    outen = 1'b0; rdone = 1'b1; card_stat = 4'hA;
    @(posedge clk); #1;
    rdone = 1'b0; card_stat = 4'h5; rbusy = 1'b0;
    if (m_state == 3) begin
      m_state = 0; m_done = 1'b1;
    end else begin
      m_full[m_fill] = 1'b1;
      m_fill = (m_fill + 1) % 2;
      m_sector = m_sector + 32'd1;
      m_count--;
      if (m_count == 0) begin
        m_state = 0; m_done = 1'b1;
      end else begin
        m_state = 1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, w;
    logic [31:0] v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_read = 1'b0; cmd_wdata = '0;
    cmd_wmask = 4'hF; rsp_ready = 1'b1; rbusy = 1'b0; rdone = 1'b0;
    card_stat = 4'h5; card_type = 2'b10; outen = 1'b0; outaddr = '0; outbyte = '0;
    m_sector = 0; m_count = 0; m_irq_en = 0; m_done = 0; m_err = 0;
    m_full = 0; m_fill = 0; m_state = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("irq_reset", 32'(irq), 32'h0);
    check("rstart_reset", 32'(rstart), 32'h0);
    check("rsp_valid_reset", 32'(rsp_valid), 32'h0);
    rd("status_reset", A_STATUS, exp_status());
    rd("sector_reset", A_SECTOR, 32'h0);
    rd("count_reset", A_COUNT, 32'h0);
    rd("ctrl_reset", A_CTRL, 32'h0);

    // two-sector transfer with a known byte pattern
    wr("wr_sector", A_SECTOR, 32'h100, 1'b0); m_sector = 32'h100;
    wr("wr_count", A_COUNT, 32'h2, 1'b0);     m_count = 2;
    wr("ctrl_start", A_CTRL, 32'h5, 1'b0);
    m_irq_en = 1'b1; m_done = 1'b0; m_state = 1;
    engine(1'b1, 1'b0);
    engine(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("irq_done", 32'(irq), 32'(m_done & m_irq_en));
    check("irq_done_const", 32'(irq), 32'h1);
    rd("status_done2", A_STATUS, exp_status());
    rd("buf0_word0", A_BUF, 32'h0302_0100);
    rd("buf1_word0", A_BUF + 32'h200, 32'h0302_0100);
    rd("count_zero", A_COUNT, 32'h0);
    rd("sector_after2", A_SECTOR, m_sector);

    // three sectors, no release in between: stalls on the third
    wr("irqclr", A_IRQCLR, 32'h0, 1'b0); m_done = 0; m_err = 0;
    wr("wr_count3", A_COUNT, 32'h3, 1'b0); m_count = 3;
    wr("ctrl_rel_start", A_CTRL, 32'h305, 1'b0);
    m_full = 2'b00; m_state = 1;
    engine(1'b0, 1'b0);
    engine(1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rstart_stalled", 32'(rstart), 32'h0);
    check("irq_stalled", 32'(irq), 32'h0);
    rd("status_stalled", A_STATUS, exp_status());
    rd("count_remaining", A_COUNT, 32'(m_count));
    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(0, 255);
      rd("buf_rand_stalled", A_BUF + 32'(4*w), mem_word(w));
    end
    wr("ctrl_release0", A_CTRL, 32'h104, 1'b0); m_full[0] = 1'b0;
    engine(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    rd("status_done3", A_STATUS, exp_status());
    @(negedge clk);
    check("irq_done3", 32'(irq), 32'h1);

    // abort in the middle of sector 0x200
    wr("wr_sector200", A_SECTOR, 32'h200, 1'b0); m_sector = 32'h200;
    wr("wr_count4", A_COUNT, 32'h4, 1'b0); m_count = 4;
    wr("ctrl_rel_start2", A_CTRL, 32'h305, 1'b0);
    m_full = 2'b00; m_done = 0; m_state = 1;
    engine(1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstart_after_abort", 32'(rstart), 32'h0);
    check("irq_after_abort", 32'(irq), 32'h1);
    rd("status_after_abort", A_STATUS, exp_status());
    rd("count_after_abort", A_COUNT, 32'h4);
    rd("sector_after_abort", A_SECTOR, 32'h200);

    // stall in WAIT_BUF, error writes while busy, then abort from WAIT_BUF
    wr("wr_count3b", A_COUNT, 32'h3, 1'b0); m_count = 3;
    wr("ctrl_start3", A_CTRL, 32'h5, 1'b0); m_done = 0; m_state = 1;
    engine(1'b0, 1'b0);
    engine(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    rd("status_wait", A_STATUS, exp_status());
    wr("sector_busy_err", A_SECTOR, 32'hDEAD, 1'b1);
    wr("count_busy_err", A_COUNT, 32'h7, 1'b1);
    wr("start_busy_err", A_CTRL, 32'h5, 1'b1); m_err = 1'b1;
    rd("status_busy_err", A_STATUS, exp_status());
    rd("sector_unchanged", A_SECTOR, m_sector);
    rd("count_unchanged", A_COUNT, 32'(m_count));
    wr("ctrl_abort_wait", A_CTRL, 32'h6, 1'b0); m_state = 0; m_done = 1'b1;
    rd("status_abort_wait", A_STATUS, exp_status());
    wr("ctrl_abort_idle", A_CTRL, 32'h6, 1'b0);
    rd("status_abort_idle", A_STATUS, exp_status());

    // error responses from IDLE
    wr("irqclr2", A_IRQCLR, 32'h1, 1'b0); m_done = 0; m_err = 0;
    wr("wr_count0", A_COUNT, 32'h0, 1'b0); m_count = 0;
    wr("start_count0_err", A_CTRL, 32'h5, 1'b1); m_err = 1'b1;
    rd("status_count0", A_STATUS, exp_status());
    wr("buf_write_err", A_BUF, 32'hFFFF_FFFF, 1'b1);
    rd("buf_after_write", A_BUF, mem_word(0));
    wr("unmapped_wr_err", 32'h14, 32'h1, 1'b1);
    icb("unmapped_rd_err", 32'h14, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    rd("status_after_errs", A_STATUS, exp_status());
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);

    // backpressure on the response channel
    drain();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rd("bp_read", A_SECTOR, m_sector);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rdata", rsp_rdata, 32'h202);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    t0 = cyc;
    icb("bp_next", A_COUNT, 1'b1, 32'h0, 32'(m_count), 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("bp_same_cycle_accept", 32'(cyc - t0), 32'h1);

    // randomized register and window traffic while idle
    for (int k = 0; k < 24; k++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: begin wr("rand_wr_sector", A_SECTOR, v, 1'b0); m_sector = v; end
        1: begin wr("rand_wr_count", A_COUNT, v, 1'b0); m_count = int'(v & 32'hFFFF); end
        2: begin
          rd("rand_rd_sector", A_SECTOR, m_sector);
          rd("rand_rd_count", A_COUNT, 32'(m_count));
        end
        default: begin
          w = $urandom_range(0, 255);
          rd("rand_rd_buf", A_BUF + 32'(4*w), mem_word(w));
        end
      endcase
    end
    rd("status_final", A_STATUS, exp_status());
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
